// File: rtl/mau_pkg.sv
// mau_pkg: shared types and helpers for the memory access unit.
// Holds the access-size and FSM-state encodings, the read-latency bound
// and the request legality check used when a request is accepted.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } mau_state_t;

    // Largest supported read latency; the latency counter is sized for it.
    localparam int MAU_MAX_LAT = 7;
    localparam int MAU_CNT_BITS = 3;

    // Illegal size or an address not aligned to the access size.
    function automatic logic mau_bad_req(input size_t sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            SZ_X:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational byte-lane steering.
// Loads: picks the addressed byte/half out of the read word and extends it.
// Stores: overlays the low store-data bits onto the addressed lane(s) of the
// read word so the whole word can be written back.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lo,
    input  size_t       i_size,
    input  logic        i_uns,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lo, 3'b000} +: 8];
    assign w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Extract/extend for loads and lane merge for stores, selected by size.
    always_comb begin
        o_load   = i_rdata;
        o_merged = i_wdata;
        case (i_size)
            SZ_B: begin
                o_load   = {{24{w_byte[7] & ~i_uns}}, w_byte};
                o_merged = i_rdata;
                o_merged[{i_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_H: begin
                o_load   = {{16{w_half[15] & ~i_uns}}, w_half};
                o_merged = i_rdata;
                o_merged[{i_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store responder in front of a
// word-wide synchronous RAM with fixed read latency MEM_LAT.
// Sub-word stores are done as read-modify-write of the containing word.
// Optional feature macro: MAU_PERF_CNT_EN adds saturating load/store/error
// counters (perf_loads, perf_stores, perf_errs); request timing is unchanged.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_uns,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MAU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_loads,
    output logic [CNT_W-1:0] perf_stores,
    output logic [CNT_W-1:0] perf_errs
`endif
);

    if (MEM_LAT < 1 || MEM_LAT > MAU_MAX_LAT || CNT_W < 1) begin : g_bad_param
        $error("mem_access_unit: MEM_LAT must be 1..7 and CNT_W >= 1");
    end

    mau_state_t              r_state;
    logic [MAU_CNT_BITS-1:0] r_cnt;
    logic                    r_write;
    size_t                   r_size;
    logic                    r_uns;
    logic [1:0]              r_lo;
    logic [31:0]             r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic [31:0]             r_rdata;
    logic                    r_err;

    logic                    w_bad;
    logic [31:0]             w_load;
    logic [31:0]             w_merged;

    assign w_bad = mau_bad_req(size_t'(req_size), req_addr[1:0]);

    // Before the merge, r_mem_wdata still holds the raw store data.
    mau_lane_align u_align (
        .i_rdata  (mem_rdata),
        .i_wdata  (r_mem_wdata),
        .i_lo     (r_lo),
        .i_size   (r_size),
        .i_uns    (r_uns),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // Request FSM: latch on accept, sequence read/wait/write, build response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_size      <= SZ_B;
            r_uns       <= 1'b0;
            r_lo        <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_size      <= size_t'(req_size);
                        r_uns       <= req_uns;
                        r_lo        <= req_addr[1:0];
                        r_mem_addr  <= {req_addr[31:2], 2'b00};
                        r_mem_wdata <= req_wdata;
                        if (w_bad) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= ST_RESP;
                        end else if (req_write && size_t'(req_size) == SZ_W) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    r_cnt   <= MAU_CNT_BITS'(MEM_LAT - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_write) begin
                            r_mem_wdata <= w_merged;
                            r_state     <= ST_WR;
                        end else begin
                            r_rdata <= w_load;
                            r_err   <= 1'b0;
                            r_state <= ST_RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_RESP;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign mem_rd    = (r_state == ST_RD);
    assign mem_wr    = (r_state == ST_WR);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

`ifdef MAU_PERF_CNT_EN
    logic [CNT_W-1:0] r_loads;
    logic [CNT_W-1:0] r_stores;
    logic [CNT_W-1:0] r_errs;

    // Saturating per-type completion counters, bumped on each response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_loads  <= '0;
            r_stores <= '0;
            r_errs   <= '0;
        end else if (rsp_valid) begin
            if (r_err) begin
                if (r_errs != '1) r_errs <= r_errs + 1'b1;
            end else if (r_write) begin
                if (r_stores != '1) r_stores <= r_stores + 1'b1;
            end else begin
                if (r_loads != '1) r_loads <= r_loads + 1'b1;
            end
        end
    end

    assign perf_loads  = r_loads;
    assign perf_stores = r_stores;
    assign perf_errs   = r_errs;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scenarios plus randomized load/store traffic
// against a word-array reference model of memory and the access rules.
module tb_mem_access_unit;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MAU_PERF_CNT_EN
    logic [15:0] perf_loads;
    logic [15:0] perf_stores;
    logic [15:0] perf_errs;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LAT(LAT), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_uns   (req_uns),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MAU_PERF_CNT_EN
        ,
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_errs   (perf_errs)
`endif
    );

    // RAM model: 64 words indexed by addr[7:2], read data after LAT cycles,
    // random junk on the bus whenever no read result is due.
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic [LAT-1:0] vpipe;
    logic [31:0] dpipe [0:LAT-1];
    logic [31:0] junk;
    logic        init_en;
    logic [5:0]  init_idx;
    logic [31:0] init_val;

    always @(posedge clk) begin
        junk <= $urandom;
        if (init_en) mem[init_idx] <= init_val;
        else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
        vpipe <= {vpipe[LAT-2:0], mem_rd};
        dpipe[0] <= mem[mem_addr[7:2]];
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign mem_rdata = vpipe[LAT-1] ? dpipe[LAT-1] : junk;

    int overlap = 0;
    always @(negedge clk) if (mem_rd && mem_wr) overlap++;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic u, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            v = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b10) return wd;
        sh   = (sz == 2'b00) ? 8 * a[1:0] : (a[1] ? 16 : 0);
        mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got);
        logic        e;
        logic [5:0]  idx;
        logic [31:0] exp_rd, exp_word;
        int exp_lat, exp_nrd, exp_nwr, cyc, nrd, nwr;
        logic done;
        e   = model_err(sz, a);
        idx = a[7:2];
        exp_word = model_store(ref_mem[idx], sz, a, wd);
        exp_rd   = (e || w) ? 32'h0 : model_load(ref_mem[idx], sz, u, a);
        if (e)                 begin exp_lat = 1;       exp_nrd = 0; exp_nwr = 0; end
        else if (!w)           begin exp_lat = 2 + LAT; exp_nrd = 1; exp_nwr = 0; end
        else if (sz == 2'b10)  begin exp_lat = 2;       exp_nrd = 0; exp_nwr = 1; end
        else                   begin exp_lat = 3 + LAT; exp_nrd = 1; exp_nwr = 1; end

        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_uns = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        cyc = 0; nrd = 0; nwr = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            // Busy-time requests must be ignored, so present random ones.
            req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
            req_uns = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            if (mem_rd) begin
                nrd++;
                chk("rd_addr", mem_addr, {a[31:2], 2'b00});
            end
            if (mem_wr) begin
                nwr++;
                chk("wr_addr", mem_addr, {a[31:2], 2'b00});
                chk("wr_data", mem_wdata, exp_word);
            end
            if (rsp_valid) begin
                done = 1'b1;
                req_valid = 1'b0;
            end
        end
        chk("latency", cyc, exp_lat);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("n_mem_rd", nrd, exp_nrd);
        chk("n_mem_wr", nwr, exp_nwr);
        if (w && !e) begin
            ref_mem[idx] = exp_word;
            chk("mem_word", mem[idx], ref_mem[idx]);
        end
        got = rsp_rdata;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        int n_wr, n_rd, n_rsp;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_uns = 1'b0; req_addr = '0; req_wdata = '0;
        init_en = 1'b0; init_idx = '0; init_val = '0;
        #2;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_rd",    {31'b0, mem_rd},    32'd0);
        chk("rst_mem_wr",    {31'b0, mem_wr},    32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            init_en  = 1'b1;
            init_idx = 6'(i);
            init_val = (i == 4) ? 32'h8899AABB : $urandom;
            ref_mem[i] = init_val;
        end
        @(negedge clk);
        init_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got);
        chk("t1_lb", got, 32'hFFFFFF88);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, got);
        chk("t2_lhu", got, 32'h00008899);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
        chk("t2_lw", got, 32'h8899AABB);
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456CC, got);
        chk("t3_sb_word", mem[4], 32'h8899CCBB);
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, got);
        chk("t4_sw_word", mem[5], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, got);
        do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, got);
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, got);
        do_req(1'b1, 2'b01, 1'b0, 32'h23, 32'h5555AAAA, got);

        // Reset while a half-word store is waiting on its read data.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_uns = 1'b0;
        req_addr = 32'h22; req_wdata = 32'h0000F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t6_rd_async", {31'b0, mem_rd}, 32'd0);
        chk("t6_wr_async", {31'b0, mem_wr}, 32'd0);
        n_wr = 0; n_rd = 0; n_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr) n_wr++;
            if (mem_rd) n_rd++;
            if (rsp_valid) n_rsp++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_wr) n_wr++;
            if (mem_rd) n_rd++;
            if (rsp_valid) n_rsp++;
        end
        chk("t6_no_wr", n_wr, 0);
        chk("t6_no_rd", n_rd, 0);
        chk("t6_no_rsp", n_rsp, 0);
        chk("t6_ready", {31'b0, req_ready}, 32'd1);
        chk("t6_mem_kept", mem[8], ref_mem[8]);

        for (int t = 0; t < 300; t++) begin
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, got);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        chk("rd_wr_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
